uart_tx_dev: RTL and testbench
==============================

Name: uart_tx_dev

Overview:
Memory-mapped UART transmitter that sits behind the system bridge as a bus responder, next to the two timers. The CPU pushes bytes through a register interface into a small FIFO. The block serialises each byte as 8N1 on a single output line and raises an interrupt once everything has drained. Its bus and interrupt signals use the same conventions as the timer devices, so it occupies one bridge device slot and one HWInt bit.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, minimum 2.
DIV_W, 16, width of the baud divisor register.
DIV_RESET, 16'd868, divisor value after reset (clocks per bit).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
Addr  input  30  word address [31:2]; only Addr[3:2] is decoded.
WE  input  1  write enable from the bridge, one cycle per store.
Din  input  32  write data.
Dout  output  32  read data, combinational from Addr[3:2] and register state.
IRQ  output  1  level interrupt to HWInt.
tx  output  1  serial line, idles high.

Behaviour:
- Register map (Addr[3:2]):
  - 00 CTRL, R/W: bit0 en, bit1 ie; other bits read 0.
  - 01 STATUS: bit0 full, bit1 empty, bit2 busy, bit3 ovf, bits[11:8] count; other bits read 0. Any write to STATUS clears ovf; all other STATUS bits ignore writes.
  - 10 DATA: a write pushes Din[7:0]; reads return 0.
  - 11 DIV, R/W: lower DIV_W bits.
- Reset (async assert, clock-sync release):
  - CTRL=0, DIV=DIV_RESET, FIFO empty (count=0), ovf=0.
  - state=IDLE, tx=1, IRQ=0, Dout reflects the reset registers.
- FIFO push:
  - On a DATA write at edge N, count increments at edge N.
  - If full, the write is dropped and ovf is set.
  - Exception: if a pop occurs at the same edge, the write is accepted and count is unchanged.
- FSM states: IDLE, START, DATA, STOP. tx is registered.
  - IDLE: when en=1 and the FIFO is non-empty at an edge, pop into an 8-bit shift register, latch DIV into div_q (values 0 or 1 are latched as 2), set tx=0 and go to START.
  - Latency: a DATA write at edge N with en=1 in IDLE gives tx low after edge N+1.
  - START: lasts div_q clocks at tx=0, then go to DATA.
  - DATA: 8 bits, LSB first, div_q clocks each; a 3-bit counter tracks the bit index; go to STOP after bit 7.
  - STOP: tx=1 for div_q clocks.
  - Leaving STOP: if en=1 and the FIFO is non-empty, pop the next byte and enter START directly (back-to-back, no idle bit). Otherwise go to IDLE.
  - One frame is exactly 10*div_q clocks.
- Baud counter: counts div_q-1 down to 0 and reloads at each bit boundary.
- busy = (state != IDLE).
- IRQ = ie & empty & !busy, driven combinationally from registers; no extra latency.
- Boundaries:
  - Clearing en mid-frame: the current frame completes; no further pops.
  - Writing DIV mid-frame: takes effect at the next frame's latch.
  - Reset mid-frame: tx goes high immediately, the FIFO is flushed and the partial byte is lost.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - count is wide enough to represent FIFO_DEPTH.
  - A push and a pop at the same edge on an empty FIFO cannot occur, because a pop requires non-empty.

Decomposition:
- Shared header: register offset defines (CTRL/STATUS/DATA/DIV), STATUS bit positions, FSM state encodings (2-bit) and the minimum divisor of 2.
- One sub-module, uart_tx_fifo: synchronous FIFO with the same clk/reset, parameterised depth and width 8. Ports: push/pop/din/dout/full/empty/count.
- Top level: register file, address decode, FSM and shifter.

Test Plan:
- Reset values: hold reset=0, then release. Expect tx=1, IRQ=0. Reads of CTRL=0, STATUS=0x00000002, DIV=868.
- Single byte: DIV=4, CTRL=1, write DATA=0xA5 at edge N.
  - tx low from edge N+1 for 4 clocks.
  - Data bits 1,0,1,0,0,1,0,1, 4 clocks each.
  - Stop bit high for 4 clocks; busy drops after 40 clocks.
- Back-to-back and IRQ: DIV=2, CTRL=3, write 0x01 then 0x02.
  - Two frames with no gap, 40 clocks total.
  - IRQ rises in the cycle busy falls with the FIFO empty.
- Overflow: CTRL=0, push 5 bytes with FIFO_DEPTH=4.
  - STATUS shows full=1, count=4, ovf=1.
  - Writing STATUS clears ovf; the 5th byte is never transmitted after setting en.
- Divisor edge and mid-frame change: DIV=0 gives 20-clock frames (treated as 2). Writing DIV=8 during a frame leaves that frame at 20 clocks; the next frame is 80 clocks.
- Reset mid-frame: assert reset during bit 3. tx goes to 1 immediately; after release, STATUS=0x00000002 and no residual frame is sent.

Source files
------------

// File: rtl/uart_tx_dev_pkg.sv
// rtl/uart_tx_dev_pkg.sv - register map, status bit positions and FSM states for uart_tx_dev
package uart_tx_dev_pkg;

   localparam logic [1:0] REG_CTRL   = 2'b00;
   localparam logic [1:0] REG_STATUS = 2'b01;
   localparam logic [1:0] REG_DATA   = 2'b10;
   localparam logic [1:0] REG_DIV    = 2'b11;

   localparam int ST_FULL_BIT  = 0;
   localparam int ST_EMPTY_BIT = 1;
   localparam int ST_BUSY_BIT  = 2;
   localparam int ST_OVF_BIT   = 3;
   localparam int ST_COUNT_LSB = 8;

   // Divisors below this would collapse a bit to a single clock or less.
   localparam int unsigned MIN_DIV = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte-wide synchronous FIFO feeding the UART shifter
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [7:0]             din,
   output logic [7:0]             dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - bus-mapped 8N1 UART transmitter with TX FIFO and drain interrupt
module uart_tx_dev
   import uart_tx_dev_pkg::*;
#(
   parameter int               FIFO_DEPTH = 4,
   parameter int               DIV_W      = 16,
   parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(868)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        tx
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e        state;
   logic             en, ie, ovf;
   logic [DIV_W-1:0] div_reg, div_q, div_eff, baud_q;
   logic [7:0]       shift_q, fifo_dout;
   logic [2:0]       bit_idx;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full, fifo_empty;
   logic             wr_ctrl, wr_status, wr_div, push_req;
   logic             busy, pop, bit_done;
   logic             unused_bits;

   assign wr_ctrl   = WE & (Addr[3:2] == REG_CTRL);
   assign wr_status = WE & (Addr[3:2] == REG_STATUS);
   assign push_req  = WE & (Addr[3:2] == REG_DATA);
   assign wr_div    = WE & (Addr[3:2] == REG_DIV);

   assign busy     = (state != S_IDLE);
   assign bit_done = (baud_q == '0);
   assign div_eff  = (div_reg < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_reg;
   // Pops happen only from IDLE or at the last clock of a stop bit.
   assign pop      = en & ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_done));
   assign IRQ      = ie & fifo_empty & ~busy;
   assign unused_bits = ^{Addr[31:4], Din};

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .din   (Din[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en      <= 1'b0;
         ie      <= 1'b0;
         ovf     <= 1'b0;
         div_reg <= DIV_RESET;
      end else begin
         if (wr_ctrl) begin
            en <= Din[0];
            ie <= Din[1];
         end
         if (wr_div) div_reg <= Din[DIV_W-1:0];
         if (wr_status)
            ovf <= 1'b0;
         else if (push_req & fifo_full & ~pop)
            ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         tx      <= 1'b1;
         shift_q <= '0;
         div_q   <= DIV_W'(MIN_DIV);
         baud_q  <= '0;
         bit_idx <= '0;
      end else if (pop) begin
         state   <= S_START;
         tx      <= 1'b0;
         shift_q <= fifo_dout;
         div_q   <= div_eff;
         baud_q  <= div_eff - DIV_W'(1);
      end else begin
         case (state)
            S_IDLE: ;
            S_START: begin
               if (bit_done) begin
                  state   <= S_DATA;
                  tx      <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_idx <= '0;
                  baud_q  <= div_q - DIV_W'(1);
               end else begin
                  baud_q  <= baud_q - DIV_W'(1);
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  baud_q <= div_q - DIV_W'(1);
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                     tx    <= 1'b1;
                  end else begin
                     tx      <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q - DIV_W'(1);
               end
            end
            S_STOP: begin
               if (bit_done) state  <= S_IDLE;
               else          baud_q <= baud_q - DIV_W'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      Dout = '0;
      case (Addr[3:2])
         REG_CTRL: Dout = {30'd0, ie, en};
         REG_STATUS: begin
            Dout[ST_FULL_BIT]          = fifo_full;
            Dout[ST_EMPTY_BIT]         = fifo_empty;
            Dout[ST_BUSY_BIT]          = busy;
            Dout[ST_OVF_BIT]           = ovf;
            Dout[ST_COUNT_LSB +: 4]    = 4'(fifo_count);
         end
         REG_DIV: Dout = 32'(div_reg);
         default: Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb/tb_uart_tx_dev.sv - scoreboard bench for uart_tx_dev: expected frames queued, tx line decoded by a monitor
module tb_uart_tx_dev;

   localparam logic [1:0] A_CTRL   = 2'b00;
   localparam logic [1:0] A_STATUS = 2'b01;
   localparam logic [1:0] A_DATA   = 2'b10;
   localparam logic [1:0] A_DIV    = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        WE = 1'b0;
   logic [31:2] Addr = '0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        IRQ;
   logic        tx;

   uart_tx_dev #(.FIFO_DEPTH(4), .DIV_W(16), .DIV_RESET(16'd868)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         div;
   } frame_t;

   frame_t exp_q[$];
   frame_t cur;
   int     starts[$];
   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   logic   mon_active = 1'b0;
   logic   prev_tx = 1'b1;
   int     mon_cnt = 0;
   int     bit_n;
   logic   exp_bit;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every falling edge on an idle line opens a frame; each of its 10*div
   // clocks is compared with the bit the queued byte calls for.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         mon_active = 1'b0;
         prev_tx    = 1'b1;
      end else if (mon_active) begin
         bit_n = mon_cnt / cur.div;
         if (bit_n == 0)      exp_bit = 1'b0;
         else if (bit_n == 9) exp_bit = 1'b1;
         else                 exp_bit = cur.data[bit_n-1];
         checkb("tx_bit", tx, exp_bit);
         mon_cnt++;
         if (mon_cnt == 10 * cur.div) mon_active = 1'b0;
         prev_tx = tx;
      end else begin
         if (prev_tx && !tx) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame: start bit seen with no queued byte (cycle %0d)", cyc);
            end else begin
               cur = exp_q.pop_front();
               starts.push_back(cyc);
               mon_active = 1'b1;
               mon_cnt    = 1;
            end
         end
         prev_tx = tx;
      end
   end

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int wcyc);
      @(negedge clk);
      Addr = {28'd0, a};
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      wcyc = cyc;
      #1 WE = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      Addr = {28'd0, a};
      WE   = 1'b0;
      #1 d = Dout;
   endtask

   task automatic push_byte(input logic [7:0] b, input int div, output int wcyc);
      frame_t f;
      f.data = b;
      f.div  = div;
      exp_q.push_back(f);
      bus_write(A_DATA, {24'd0, b}, wcyc);
   endtask

   task automatic wait_idle(input logic exp_irq, output int fall_cyc);
      logic seen;
      logic prev_irq;
      seen     = 1'b0;
      prev_irq = 1'b0;
      fall_cyc = -1;
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         Addr = {28'd0, A_STATUS};
         #1;
         if (Dout[2]) begin
            seen     = 1'b1;
            prev_irq = IRQ;
         end else if (seen) begin
            fall_cyc = cyc;
            break;
         end
      end
      checkb("busy_fall_seen", fall_cyc >= 0, 1'b1);
      if (fall_cyc >= 0) begin
         checkb("irq_while_busy", prev_irq, 1'b0);
         checkb("irq_at_idle", IRQ, exp_irq);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [7:0]  b;
      logic        c;
      int          w0, w1, wx, fall, s0, d, eff, n;

      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkb("reset_tx", tx, 1'b1);
      checkb("reset_irq", IRQ, 1'b0);
      @(negedge clk);
      #2 reset = 1'b1;
      bus_read(A_CTRL, rd);   check("reset_ctrl", rd, 0);
      bus_read(A_STATUS, rd); check("reset_status", rd, 32'h2);
      bus_read(A_DIV, rd);    check("reset_div", rd, 868);
      bus_read(A_DATA, rd);   check("data_reads_zero", rd, 0);
      checkb("post_reset_tx", tx, 1'b1);

      // Single byte, divisor 4
      bus_write(A_DIV, 4, wx);
      bus_write(A_CTRL, 1, wx);
      s0 = starts.size();
      push_byte(8'hA5, 4, w0);
      wait_idle(1'b0, fall);
      check("single_frames", starts.size() - s0, 1);
      if (starts.size() > s0) begin
         check("single_latency", starts[s0], w0 + 2);
         check("single_len", fall - starts[s0], 40);
      end

      // Back-to-back with interrupt enabled
      bus_write(A_DIV, 2, wx);
      bus_write(A_CTRL, 3, wx);
      s0 = starts.size();
      push_byte(8'h01, 2, w0);
      push_byte(8'h02, 2, w1);
      wait_idle(1'b1, fall);
      check("b2b_frames", starts.size() - s0, 2);
      if (starts.size() > s0 + 1) begin
         check("b2b_latency", starts[s0], w0 + 2);
         check("b2b_gap", starts[s0+1] - starts[s0], 20);
         check("b2b_total", fall - starts[s0], 40);
      end

      // Overflow with transmitter disabled
      bus_write(A_CTRL, 0, wx);
      bus_write(A_DIV, 2, wx);
      for (int i = 0; i < 4; i++) push_byte(8'($urandom), 2, wx);
      bus_write(A_DATA, {24'd0, 8'($urandom)}, wx);
      bus_read(A_STATUS, rd); check("ovf_status", rd, 32'h409);
      bus_write(A_STATUS, $urandom, wx);
      bus_read(A_STATUS, rd); check("ovf_cleared", rd, 32'h401);
      s0 = starts.size();
      bus_write(A_CTRL, 1, wx);
      wait_idle(1'b0, fall);
      check("ovf_frames", starts.size() - s0, 4);
      bus_read(A_STATUS, rd); check("ovf_drained", rd, 32'h2);

      // DIV=0 clamps to 2; DIV rewritten mid-frame applies to the next frame
      bus_write(A_DIV, 0, wx);
      s0 = starts.size();
      push_byte(8'($urandom), 2, w0);
      push_byte(8'($urandom), 8, w1);
      bus_write(A_DIV, 8, wx);
      wait_idle(1'b0, fall);
      check("divchg_frames", starts.size() - s0, 2);
      if (starts.size() > s0 + 1) begin
         check("divchg_first_len", starts[s0+1] - starts[s0], 20);
         check("divchg_second_len", fall - starts[s0+1], 80);
      end
      bus_read(A_DIV, rd); check("div_readback", rd, 8);

      // Random divisors and burst lengths
      for (int r = 0; r < 4; r++) begin
         d   = $urandom_range(0, 5);
         eff = (d < 2) ? 2 : d;
         c   = 1'($urandom_range(0, 1));
         n   = $urandom_range(1, 4);
         bus_write(A_DIV, d, wx);
         bus_write(A_CTRL, {30'd0, c, 1'b1}, wx);
         s0 = starts.size();
         push_byte(8'($urandom), eff, w0);
         for (int k = 1; k < n; k++) push_byte(8'($urandom), eff, wx);
         wait_idle(c, fall);
         check("rand_frames", starts.size() - s0, n);
         if (starts.size() >= s0 + n) begin
            check("rand_latency", starts[s0], w0 + 2);
            check("rand_span", starts[s0+n-1] - starts[s0], (n - 1) * 10 * eff);
            check("rand_total", fall - starts[s0], n * 10 * eff);
         end
      end

      // Reset during data bit 3 (first byte has bit 3 clear so the line is low)
      bus_write(A_DIV, 4, wx);
      bus_write(A_CTRL, 1, wx);
      s0 = starts.size();
      b  = 8'($urandom) & 8'hF7;
      push_byte(b, 4, wx);
      push_byte(8'($urandom), 4, wx);
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         #1;
         if (starts.size() > s0) break;
      end
      check("rst_mid_started", starts.size() - s0, 1);
      repeat (17) @(negedge clk);
      #1 checkb("rst_mid_pre_tx", tx, 1'b0);
      #1 reset = 1'b0;
      #1 checkb("rst_mid_tx", tx, 1'b1);
      exp_q.delete();
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      bus_read(A_STATUS, rd); check("rst_mid_status", rd, 32'h2);
      bus_read(A_CTRL, rd);   check("rst_mid_ctrl", rd, 0);
      s0 = starts.size();
      repeat (200) @(negedge clk);
      check("rst_mid_no_frame", starts.size() - s0, 0);
      checkb("rst_mid_idle_tx", tx, 1'b1);

      check("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
